// File: rtl/count_compare_ctrl_pkg.sv
// Shared encodings and defaults for the compare/reload controller.
package count_compare_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_EVT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RELOAD = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/count_compare_ctrl_wrap_detect.sv
// Genuine-wrap detector: flags a 0xFF->0x00 step that the counter made by
// counting, not one caused by a preset load.
module count_wrap_detect
  import count_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             preset,
  output logic             wrap_pulse
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             preset_q, preset_d;

  // previous-cycle count and preset, used to qualify the wrap
  always_comb begin
    count_d  = count;
    preset_d = preset;
  end

  // history registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      preset_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      preset_q <= preset_d;
    end
  end

  // a load of 0x00 right after 0xFF shows preset_q = 1 and is ignored
  always_comb begin
    wrap_pulse = (count_q == '1) && (count == '0) && !preset_q;
  end

endmodule

// File: rtl/count_compare_ctrl.sv
// Compare-match controller for the 8-bit up-counter: issues a registered
// preset/reload on match (one-shot or periodic), counts matches with
// saturation, and keeps sticky irq / genuine-wrap flags.
module count_compare_ctrl
  import count_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EVT_W = DEF_EVT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             arm,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic [WIDTH-1:0] reload_value,
  input  logic             irq_clr,
  output logic             preset,
  output logic [WIDTH-1:0] load_value,
  output logic             irq,
  output logic             wrap_flag,
  output logic [EVT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic             preset_q, preset_d;
  logic [WIDTH-1:0] load_value_q, load_value_d;
  logic             irq_q, irq_d;
  logic             wrap_flag_q, wrap_flag_d;
  logic [EVT_W-1:0] match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0] cmp_sh_q, cmp_sh_d;
  logic [WIDTH-1:0] rld_sh_q, rld_sh_d;
  logic             mode_q, mode_d;

  logic             match;
  logic             irq_set;
  logic             wrap_pulse;

  count_wrap_detect #(.WIDTH(WIDTH)) u_wrap (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .preset     (preset_q),
    .wrap_pulse (wrap_pulse)
  );

  // compare only while ARMED; RELOAD shows cmp+1 and must not re-match
  always_comb begin
    match = (state_q == ST_ARMED) && (count == cmp_sh_q);
  end

  // next state and registered outputs; priority stop > arm > match
  always_comb begin
    state_d      = state_q;
    preset_d     = 1'b0;
    load_value_d = load_value_q;
    match_cnt_d  = match_cnt_q;
    cmp_sh_d     = cmp_sh_q;
    rld_sh_d     = rld_sh_q;
    mode_d       = mode_q;
    irq_set      = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      cmp_sh_d    = cmp_value;
      rld_sh_d    = reload_value;
      mode_d      = mode;
      match_cnt_d = '0;
      state_d     = ST_ARMED;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (match) begin
            preset_d     = 1'b1;
            load_value_d = rld_sh_q;
            irq_set      = 1'b1;
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + EVT_W'(1);
            state_d      = ST_RELOAD;
          end
        end
        ST_RELOAD: state_d = (mode_q == MODE_PERIODIC) ? ST_ARMED : ST_DONE;
        default:   state_d = state_q;
      endcase
    end

    // a set in the same cycle as a clear keeps the flag high
    irq_d       = irq_set    | (irq_q       & ~irq_clr);
    wrap_flag_d = wrap_pulse | (wrap_flag_q & ~irq_clr);
  end

  // controller state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      preset_q     <= 1'b0;
      load_value_q <= '0;
      irq_q        <= 1'b0;
      wrap_flag_q  <= 1'b0;
      match_cnt_q  <= '0;
      cmp_sh_q     <= '0;
      rld_sh_q     <= '0;
      mode_q       <= MODE_ONESHOT;
    end else begin
      state_q      <= state_d;
      preset_q     <= preset_d;
      load_value_q <= load_value_d;
      irq_q        <= irq_d;
      wrap_flag_q  <= wrap_flag_d;
      match_cnt_q  <= match_cnt_d;
      cmp_sh_q     <= cmp_sh_d;
      rld_sh_q     <= rld_sh_d;
      mode_q       <= mode_d;
    end
  end

  assign preset     = preset_q;
  assign load_value = load_value_q;
  assign irq        = irq_q;
  assign wrap_flag  = wrap_flag_q;
  assign match_cnt  = match_cnt_q;
  assign state      = state_q;

endmodule
